// File: rtl/seed_word_io_if.sv
// Word-stream port bundle for seed_word_io: text/key input stream and result output stream.
// With SEED_KEY_CACHE_EN defined the bundle also carries i_fKeyReuse.
interface seed_word_io_if #(
  parameter int unsigned WORD_W = 32
);
  logic              i_Valid;
  logic              o_Ready;
  logic [WORD_W-1:0] i_Data;
  logic              i_fDec;
  logic              o_Valid;
  logic              i_Ready;
  logic [WORD_W-1:0] o_Data;
  logic              o_Last;
`ifdef SEED_KEY_CACHE_EN
  logic              i_fKeyReuse;

  modport slave (
    input  i_Valid, i_Data, i_fDec, i_Ready, i_fKeyReuse,
    output o_Ready, o_Valid, o_Data, o_Last
  );
  modport master (
    output i_Valid, i_Data, i_fDec, i_Ready, i_fKeyReuse,
    input  o_Ready, o_Valid, o_Data, o_Last
  );
`else
  modport slave (
    input  i_Valid, i_Data, i_fDec, i_Ready,
    output o_Ready, o_Valid, o_Data, o_Last
  );
  modport master (
    output i_Valid, i_Data, i_fDec, i_Ready,
    input  o_Ready, o_Valid, o_Data, o_Last
  );
`endif
endinterface

// File: rtl/seed_word_io.sv
// Word-serial front end for the SEED128 core: loads text and key, replays them to the core,
// streams the result out. SEED_KEY_CACHE_EN enables replay of the last loaded key.
module seed_word_io #(
  parameter int unsigned WORD_W = 32
) (
  input  logic           i_Clk,
  input  logic           i_Rst,
  seed_word_io_if.slave  bus,
  output logic           o_Busy,
  output logic [127:0]   o_CoreText,
  output logic           o_CoreStart,
  output logic           o_CoreDec,
  input  logic [127:0]   i_CoreText,
  input  logic           i_CoreDone
);
  localparam int unsigned NWORD = 128 / WORD_W;
  localparam int unsigned CNT_W = (NWORD > 1) ? $clog2(NWORD) : 1;

  typedef enum logic [2:0] {StLdTxt, StLdKey, StStart, StKey, StWait, StOut} state_e;

  state_e             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [127:0]       r_text, w_text;
  logic [127:0]       r_key, w_key;
  logic [127:0]       r_res, w_res;
  logic               r_dec, w_dec;
  logic               w_load, w_accept, w_last_word;
`ifdef SEED_KEY_CACHE_EN
  logic               r_key_vld, w_key_vld;
  logic               r_reuse, w_reuse;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state   <= StLdTxt;
      r_cnt     <= '0;
      r_text    <= '0;
      r_key     <= '0;
      r_res     <= '0;
      r_dec     <= 1'b0;
`ifdef SEED_KEY_CACHE_EN
      r_key_vld <= 1'b0;
      r_reuse   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_text    <= w_text;
      r_key     <= w_key;
      r_res     <= w_res;
      r_dec     <= w_dec;
`ifdef SEED_KEY_CACHE_EN
      r_key_vld <= w_key_vld;
      r_reuse   <= w_reuse;
`endif
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_text      = r_text;
    w_key       = r_key;
    w_res       = r_res;
    w_dec       = r_dec;
`ifdef SEED_KEY_CACHE_EN
    w_key_vld   = r_key_vld;
    w_reuse     = r_reuse;
`endif
    w_load      = (r_state == StLdTxt) || (r_state == StLdKey);
    w_accept    = bus.i_Valid && w_load;
    w_last_word = (r_cnt == CNT_W'(NWORD - 1));
    unique case (r_state)
      StLdTxt: begin
        if (w_accept) begin
          w_text = {r_text[127-WORD_W:0], bus.i_Data};
          if (r_cnt == '0) begin
            w_dec = bus.i_fDec;
`ifdef SEED_KEY_CACHE_EN
            w_reuse = bus.i_fKeyReuse;
`endif
          end
          if (w_last_word) begin
            w_cnt   = '0;
            w_state = StLdKey;
`ifdef SEED_KEY_CACHE_EN
            if (w_reuse && r_key_vld) w_state = StStart;
`endif
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      StLdKey: begin
        if (w_accept) begin
          w_key = {r_key[127-WORD_W:0], bus.i_Data};
          if (w_last_word) begin
            w_cnt   = '0;
            w_state = StStart;
`ifdef SEED_KEY_CACHE_EN
            w_key_vld = 1'b1;
`endif
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      StStart: w_state = StKey;
      StKey:   w_state = StWait;
      StWait: begin
        if (i_CoreDone) begin
          w_res   = i_CoreText;
          w_cnt   = '0;
          w_state = StOut;
        end
      end
      StOut: begin
        // Result shifts left so the current word always sits in the top slice.
        if (bus.i_Ready) begin
          w_res = {r_res[127-WORD_W:0], {WORD_W{1'b0}}};
          if (w_last_word) begin
            w_cnt   = '0;
            w_state = StLdTxt;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state = StLdTxt;
    endcase
  end

  always_comb begin
    bus.o_Ready = (r_state == StLdTxt) || (r_state == StLdKey);
    bus.o_Valid = (r_state == StOut);
    bus.o_Data  = r_res[127 -: WORD_W];
    bus.o_Last  = (r_state == StOut) && (r_cnt == CNT_W'(NWORD - 1));
    o_Busy      = (r_state != StLdTxt);
    o_CoreStart = (r_state == StStart);
    o_CoreDec   = r_dec && (r_state != StLdTxt) && (r_state != StLdKey);
    o_CoreText  = '0;
    if (r_state == StStart) o_CoreText = r_text;
    if (r_state == StKey)   o_CoreText = r_key;
  end
endmodule

// File: doc/seed_word_io.md
Name: seed_word_io

Overview:
Word-serial front end for the SEED128 encrypt/decrypt core. It collects a 128-bit text block and a 128-bit key from a narrow valid/ready input stream and replays them to the core in the required two-cycle sequence: text with start, then key. It waits for the core's one-cycle done, captures the 128-bit result, and streams it out as words over a valid/ready output port. It sits directly upstream and downstream of the core, between the core and the bus/host interface.

Parameters:
WORD_W, 32, stream word width; legal values are 8, 16, 32, 64 (must divide 128)
NWORD, 128/WORD_W, words per 128-bit block; localparam, not overridable

Ports:
i_Clk  in  1  clock
i_Rst  in  1  reset, asynchronous, active-low
i_Valid  in  1  input word valid
o_Ready  out  1  input word accepted when i_Valid & o_Ready
i_Data  in  WORD_W  input word; MS word first
i_fDec  in  1  decrypt select; sampled on the first text word only
o_Valid  out  1  output word valid
i_Ready  in  1  downstream ready
o_Data  out  WORD_W  output word; MS word first
o_Last  out  1  marks the final (NWORD-th) output word
o_Busy  out  1  high whenever state is not LD_TXT
o_CoreText  out  128  to core i_Text
o_CoreStart  out  1  to core i_fStart
o_CoreDec  out  1  to core i_fDec
i_CoreText  in  128  from core o_Text
i_CoreDone  in  1  from core o_fDone

Behaviour:
- Reset (async, i_Rst=0): state LD_TXT, word counter 0, text/key/result registers 0, dec flag 0. All outputs 0 except o_Ready=1.
- States: LD_TXT, LD_KEY, START, KEY, WAIT, OUT.
- LD_TXT: o_Ready=1. Each accepted word shifts into the text register (first word lands in [127:128-WORD_W]). The first word latches i_fDec. After the NWORD-th word, go to LD_KEY (or START; see the optional feature). Counter resets to 0.
- LD_KEY: o_Ready=1. Same shift into the key register. After the NWORD-th word, go to START.
- START (1 cycle): o_CoreStart=1, o_CoreText=text, o_CoreDec=dec flag. Next state KEY.
- KEY (1 cycle): o_CoreText=key, o_CoreStart=0. Next state WAIT.
- WAIT: o_CoreText=0. On i_CoreDone=1, capture i_CoreText into the result register and go to OUT. No timeout.
- OUT: o_Valid=1, o_Data=result[127 -: WORD_W] for word index k. o_Last=1 when k=NWORD-1. Advance only on i_Ready.
  - While i_Ready=0, o_Data and o_Last hold stable.
  - After the last handshake, go to LD_TXT with o_Ready=1 in the next cycle.
- o_Ready=0 in START, KEY, WAIT and OUT. Words presented then are not consumed.
- o_CoreDec is held for the whole operation and is 0 in load states.
- i_CoreDone outside WAIT is ignored; no capture, no state change.
- Latency, last key word to first o_Valid: 3 cycles + core latency (START, KEY, capture edge).
- Back-to-back: no idle cycle is required between the last output handshake and the first word of the next block.
- Reset mid-operation clears everything. Any partial input or output block is discarded.

Optional Feature:
- Macro SEED_KEY_CACHE_EN.
- Defined: adds port i_fKeyReuse (in, 1), sampled on the first text word.
  - If i_fKeyReuse=1 and a key has been fully loaded since reset (key_vld flag), LD_TXT goes directly to START after the last text word and the stored key is replayed in KEY.
  - If key_vld=0, i_fKeyReuse is ignored and LD_KEY is entered.
  - key_vld is cleared by reset and set on completion of LD_KEY.
- Undefined: the port is absent and every block loads a key.

Test Plan:
- Encrypt, WORD_W=32, real SEED core: text 00010203_04050607_08090A0B_0C0D0E0F, key all-0, i_fDec=0 -> 4 output words 5EBAC6E0, 054E1668, 19AFF1CC, 6D346CDB; o_Last only on the 4th word.
- Decrypt: feed 5EBAC6E0...6D346CDB with key 0 and i_fDec=1 -> 00010203...0C0D0E0F; o_CoreDec=1 from START to done.
- Core handshake check: o_CoreStart high exactly 1 cycle carrying text, immediately followed by 1 cycle carrying key; o_Ready=0 from START until the last output handshake.
- Backpressure: i_Ready low for 5 cycles on word 2 -> o_Data is stable and no word is skipped or duplicated. i_Valid toggling every other cycle on input -> the same ciphertext as the first scenario.
- Stray i_CoreDone pulse in LD_TXT -> no state change. Assert i_Rst in WAIT -> all outputs reset, o_Ready=1, and the next full block encrypts correctly.
- SEED_KEY_CACHE_EN:
  - Run the first scenario, then send the same text with i_fKeyReuse=1 -> only 4 words consumed, same ciphertext.
  - i_fKeyReuse=1 immediately after reset -> the key phase is still entered.
